// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer and its result masking:
// opcode map, sequencer states and the default operand width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [3:0] OP_OR_R  = 4'b0000;
  localparam logic [3:0] OP_AND_R = 4'b0001;
  localparam logic [3:0] OP_XOR_R = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_EQ    = 4'b0110;
  localparam logic [3:0] OP_NE    = 4'b0111;
  localparam logic [3:0] OP_LT    = 4'b1000;
  localparam logic [3:0] OP_GE    = 4'b1001;
  localparam logic [3:0] OP_ADD   = 4'b1010;
  localparam logic [3:0] OP_SUB   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_SHL   = 4'b1101;
  localparam logic [3:0] OP_SHR   = 4'b1110;
  localparam logic [3:0] OP_NOT   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_result_mask.sv
// Turns raw ALU result nibbles into the architecturally visible result:
// keeps only the bits each opcode defines, and derives zero/carry flags.
module alu_result_mask import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]         opcode_i,
  input  logic [WIDTH-1:0]   alu_x_i,
  input  logic [WIDTH-1:0]   alu_y_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               zero_o,
  output logic               carry_o
);

  always_comb begin
    result_o = '0;
    case (opcode_i)
      // predicates and reductions produce a single meaningful bit
      OP_OR_R, OP_AND_R, OP_XOR_R,
      OP_EQ, OP_NE, OP_LT, OP_GE:     result_o[0] = alu_x_i[0];
      OP_AND, OP_OR, OP_XOR,
      OP_SUB, OP_NOT:                 result_o[WIDTH-1:0] = alu_x_i;
      OP_ADD:                         result_o[WIDTH:0] = {alu_y_i[0], alu_x_i};
      OP_MUL, OP_SHL, OP_SHR:         result_o = {alu_y_i, alu_x_i};
      default:                        result_o = '0;
    endcase
  end

  assign zero_o  = (result_o == '0);
  assign carry_o = (opcode_i == OP_ADD) && alu_y_i[0];

endmodule

// File: rtl/alu_seq.sv
// Single-issue sequencer in front of an external combinational ALU:
// accept a request, hold ALU inputs for one cycle, capture the masked result.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_use_acc,
  output logic [3:0]         alu_opcode,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_x,
  input  logic [WIDTH-1:0]   alu_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [3:0]         out_opcode,
  output logic               out_zero,
  output logic               out_carry,
  output logic [CNT_W-1:0]   op_count,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [3:0]         alu_op_q, out_op_q;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [2*WIDTH-1:0] res_q, acc_q, mask_res;
  logic               zero_q, carry_q, mask_zero, mask_carry;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, out_hs;

  alu_result_mask #(.WIDTH(WIDTH)) u_mask (
    .opcode_i (alu_op_q),
    .alu_x_i  (alu_x),
    .alu_y_i  (alu_y),
    .result_o (mask_res),
    .zero_o   (mask_zero),
    .carry_o  (mask_carry)
  );

  assign accept = in_valid && (state_q == ST_IDLE);
  assign out_hs = out_ready && (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      res_q    <= '0;
      out_op_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      // ALU inputs only move on acceptance, so the ALU never sees a glitch
      if (accept) begin
        alu_op_q <= in_opcode;
        alu_a_q  <= in_use_acc ? acc_q[WIDTH-1:0] : in_a;
        alu_b_q  <= in_b;
      end
      if (state_q == ST_EXEC) begin
        res_q    <= mask_res;
        out_op_q <= alu_op_q;
        zero_q   <= mask_zero;
        carry_q  <= mask_carry;
        acc_q    <= mask_res;
      end
      if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Upper accumulator half is kept for architectural visibility only.
  logic acc_unused;
  assign acc_unused = ^acc_q[2*WIDTH-1:WIDTH];

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_result = res_q;
  assign out_opcode = out_op_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a behavioural ALU drives alu_x/alu_y (with junk
// in undefined bits), and a semantic model is compared on every cycle.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_use_acc, out_valid, out_ready;
  logic [3:0] in_opcode, in_a, in_b, alu_opcode, alu_a, alu_b, alu_x, alu_y, out_opcode;
  logic [7:0] out_result, op_count;
  logic       out_zero, out_carry, busy;

  int n_vec = 0, n_err = 0;
  bit cmp_en = 0;

  alu_seq #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_x(alu_x), .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode), .out_zero(out_zero),
    .out_carry(out_carry), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU: {y,x}; bits outside each opcode's defined result are junk.
  function automatic logic [7:0] alu_f(input logic [3:0] op, a, b);
    logic [7:0] r;
    case (op)
      4'd0:  r = {4'h5, 3'b101, |a};
      4'd1:  r = {4'hA, 3'b110, &a};
      4'd2:  r = {4'h6, 3'b011, ^a};
      4'd3:  r = {~(a & b), a & b};
      4'd4:  r = {~(a | b), a | b};
      4'd5:  r = {4'hC, a ^ b};
      4'd6:  r = {4'h3, 3'b111, a == b};
      4'd7:  r = {4'h7, 3'b010, a != b};
      4'd8:  r = {4'hB, 3'b100, a < b};
      4'd9:  r = {4'hD, 3'b001, a >= b};
      4'd10: r = {4'b0, a} + {4'b0, b};
      4'd11: r = {4'hF, a - b};
      4'd12: r = {4'b0, a} * {4'b0, b};
      4'd13: r = {4'b0, a} << b[1:0];
      4'd14: r = {a, 4'b0} >> b[1:0];
      default: r = {4'h9, ~a};
    endcase
    return r;
  endfunction

  always_comb {alu_y, alu_x} = alu_f(alu_opcode, alu_a, alu_b);

  // Expected architectural result {carry, result} straight from operation meaning.
  function automatic logic [8:0] sem(input logic [3:0] op, a, b);
    int ia, ib, r;
    logic c;
    ia = a; ib = b; c = 0;
    case (op)
      4'd0:  r = (ia != 0);
      4'd1:  r = (ia == 15);
      4'd2:  r = ^a;
      4'd3:  r = ia & ib;
      4'd4:  r = ia | ib;
      4'd5:  r = ia ^ ib;
      4'd6:  r = (ia == ib);
      4'd7:  r = (ia != ib);
      4'd8:  r = (ia < ib);
      4'd9:  r = (ia >= ib);
      4'd10: begin r = ia + ib; c = (r >= 16); end
      4'd11: r = (ia - ib + 16) % 16;
      4'd12: r = ia * ib;
      4'd13: r = (ia * (1 << (ib % 4))) % 256;
      4'd14: r = (ia * 16) / (1 << (ib % 4));
      default: r = 15 - ia;
    endcase
    return {c, 8'(r)};
  endfunction

  // Model: outstanding request, its age in cycles, accumulator, count.
  bit         m_pend = 0;
  int         m_age = 0;
  logic [3:0] m_op = 0, m_a = 0, m_b = 0;
  logic [8:0] m_exp = 0;
  logic [7:0] m_acc = 0, m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 0; m_age <= 0; m_acc <= 0; m_cnt <= 0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend <= 1; m_age <= 0; m_op <= in_opcode; m_b <= in_b;
        m_a   <= in_use_acc ? m_acc[3:0] : in_a;
        m_exp <= sem(in_opcode, in_use_acc ? m_acc[3:0] : in_a, in_b);
      end
    end else if (m_age == 0) begin
      m_age <= 1; m_acc <= m_exp[7:0];
    end else if (out_ready) begin
      m_pend <= 0; m_cnt <= m_cnt + 8'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_pend && m_age == 1));
      chk("in_ready", 32'(in_ready), 32'(!m_pend));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("op_count", 32'(op_count), 32'(m_cnt));
      if (m_pend) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
      end
      if (m_pend && m_age == 1) begin
        chk("out_result", 32'(out_result), 32'(m_exp[7:0]));
        chk("out_opcode", 32'(out_opcode), 32'(m_op));
        chk("out_zero", 32'(out_zero), 32'(m_exp[7:0] == 8'h00));
        chk("out_carry", 32'(out_carry), 32'(m_exp[8]));
      end
    end
  end

  logic [7:0] last_res;
  logic [3:0] last_a;
  logic       last_zero, last_carry;

  // One request; hold>0 keeps out_ready low that many DONE cycles while a
  // competing request is offered.
  task automatic do_op(input logic [3:0] op, a, b, input logic ua, input int hold);
    int t;
    in_opcode = op; in_a = a; in_b = b; in_use_acc = ua; in_valid = 1;
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("latency", 32'(out_valid), 32'd1);
    last_res = out_result; last_zero = out_zero; last_carry = out_carry; last_a = alu_a;
    if (hold > 0) begin
      in_opcode = 4'd12; in_a = 4'h7; in_b = 4'h7; in_valid = 1;
      repeat (hold) begin @(posedge clk); #1; end
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(out_result), 32'(last_res));
      out_ready = 1;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_opcode = 0; in_a = 0; in_b = 0; in_use_acc = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst = 0; cmp_en = 1;

    do_op(4'b1010, 4'd9, 4'd8, 0, 0);
    chk("add_result", 32'(last_res), 32'h11);
    chk("add_carry", 32'(last_carry), 32'd1);
    chk("add_zero", 32'(last_zero), 32'd0);

    do_op(4'b1100, 4'hF, 4'hF, 0, 0);
    chk("mul_result", 32'(last_res), 32'hE1);
    do_op(4'b0011, 4'h0, 4'h3, 1, 0);
    chk("acc_alu_a", 32'(last_a), 32'd1);
    chk("acc_result", 32'(last_res), 32'h01);

    do_op(4'b0110, 4'd2, 4'd5, 0, 0);
    chk("eq_result", 32'(last_res), 32'h00);
    chk("eq_zero", 32'(last_zero), 32'd1);

    do_op(4'd0, 4'h0, 4'h0, 0, 0);
    do_op(4'd1, 4'hF, 4'h2, 0, 0);
    do_op(4'd2, 4'h7, 4'h0, 0, 0);
    do_op(4'd4, 4'h9, 4'h6, 0, 0);
    do_op(4'd5, 4'hA, 4'h3, 0, 0);
    do_op(4'd7, 4'h4, 4'h4, 0, 0);
    do_op(4'd8, 4'h3, 4'h9, 0, 0);
    do_op(4'd9, 4'h3, 4'h9, 0, 0);
    do_op(4'd11, 4'h3, 4'h5, 0, 0);
    do_op(4'd13, 4'h5, 4'h3, 0, 0);
    chk("shl_result", 32'(last_res), 32'h28);
    do_op(4'd14, 4'hC, 4'h2, 0, 0);
    do_op(4'd15, 4'hA, 4'h0, 0, 0);
    do_op(4'd10, 4'hF, 4'hF, 0, 5);
    chk("hold_add_result", 32'(last_res), 32'h1E);

    // Reset while the request is in EXEC discards it.
    in_opcode = 4'd12; in_a = 4'h5; in_b = 4'h3; in_use_acc = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_exec_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exec_count", 32'(op_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec_valid", 32'(out_valid), 32'd0);
    do_op(4'd4, 4'h0, 4'h6, 1, 0);
    chk("rst_exec_acc", 32'(last_a), 32'd0);

    rst = 1; @(posedge clk); #1; rst = 0;
    for (int i = 0; i < 255; i++)
      do_op(4'(i % 16), 4'(i), 4'(i >> 4), (i % 3) == 0, 0);
    chk("count_255", 32'(op_count), 32'd255);
    do_op(4'd3, 4'h6, 4'h5, 0, 0);
    chk("count_wrap", 32'(op_count), 32'd0);

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand/opcode-nibble width; result width is 2*WIDTH.
REQ-002 Parameter CNT_W, default 8, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present; in_ready  output  1  request accepted when both high.
REQ-006 in_opcode  input  4  operation code; in_a, in_b  input  WIDTH  operands.
REQ-007 in_use_acc  input  1  when high, operand a is taken from the accumulator instead of in_a.
REQ-008 alu_opcode  output  4; alu_a, alu_b  output  WIDTH  registered drive to the downstream ALU.
REQ-009 alu_x, alu_y  input  WIDTH  ALU low/high result nibbles, combinational from alu_* outputs.
REQ-010 out_valid  output  1; out_ready  input  1  result handshake, transfer when both high.
REQ-011 out_result  output  2*WIDTH  masked result; out_opcode  output  4  opcode of that result.
REQ-012 out_zero, out_carry  output  1  flags; op_count  output  CNT_W  completed-operation count; busy  output  1.

Function
REQ-013 FSM states IDLE, EXEC, DONE; in_ready SHALL be 1 only in IDLE; busy = (state != IDLE).
REQ-014 IDLE: on in_valid&in_ready, latch opcode, a (in_a or acc[WIDTH-1:0] per in_use_acc), b into alu_* registers; go EXEC.
REQ-015 EXEC: exactly one cycle; alu_* held stable; at its end capture masked {alu_y,alu_x} into out_result, opcode, flags; go DONE.
REQ-016 DONE: out_valid=1, outputs held stable until out_valid&out_ready, then IDLE; out_valid SHALL be 0 in IDLE/EXEC.
REQ-017 Latency: out_valid rises 2 cycles after the accepting edge; minimum issue interval 3 cycles; no bypass of DONE->EXEC.
REQ-018 Masking: opcodes 0000-0010, 0110-1001 -> {zeros, alu_x[0]}; 0011-0101, 1011, 1111 -> {zeros, alu_x}.
REQ-019 Masking: 1010 -> {zeros, alu_y[0], alu_x}; 1100-1110 -> {alu_y, alu_x}.
REQ-020 out_zero = (masked result == 0); out_carry = alu_y[0] for opcode 1010, else 0.
REQ-021 Accumulator (2*WIDTH bits) SHALL load masked result at EXEC end; otherwise holds.
REQ-022 in_use_acc in the same request as a result capture is impossible (single-issue); acc read is always the previous completed result.
REQ-023 op_count increments by 1 at each out handshake, wraps from 2^CNT_W-1 to 0.
REQ-024 alu_* registers SHALL retain last issued values while IDLE/DONE (no glitching of ALU inputs).
REQ-025 in_valid deassertion before acceptance is legal; in_* are ignored outside IDLE.

Reset
REQ-026 On rst: state IDLE, alu_a/alu_b/alu_opcode=0, out_result=0, out_opcode=0, out_zero=0, out_carry=0, acc=0, op_count=0, out_valid=0.
REQ-027 rst during EXEC or DONE SHALL discard the operation; no handshake, no count increment; in_ready=1 the cycle after rst deasserts.
REQ-028 rst has priority over every simultaneous handshake.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (OP_OR_R ... OP_NOT), the state enum, and WIDTH default.
REQ-030 Result masking and flag generation SHALL be one combinational sub-module alu_result_mask, shared with any future ALU consumer.
REQ-031 The ALU itself is external; alu_seq SHALL contain no arithmetic beyond masking, compare-to-zero, and the counter.

Verification
REQ-032 Opcode 1010, a=9, b=8, ALU model -> out_result=0x11, out_carry=1, out_zero=0, out_valid 2 cycles after accept.
REQ-033 Opcode 1100, a=0xF, b=0xF -> out_result=0xE1; then opcode 0011, in_use_acc=1, b=0x3 -> alu_a=1, out_result=0x01.
REQ-034 Opcode 0110, a=2, b=5, ALU drives alu_x=4'hE garbage upper bits -> out_result=0x00, out_zero=1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_result/out_valid stable, in_ready=0, new in_valid ignored.
REQ-036 rst pulsed during EXEC -> out_valid never rises, op_count=0, acc=0, in_ready=1 next cycle.
REQ-037 256 back-to-back completed ops with CNT_W=8 -> op_count wraps to 0.
